// File: rtl/reg_file_if.sv
// -----------------------------------------------------------------------------
// reg_file_if
// Bundles the write, clear and dual read-port signals of reg_file.
//   clr                 synchronous clear of every register
//   we/waddr/wdata      write port
//   re_a/raddr_a        read request and address, port A
//   rdata_a/rvalid_a    registered read data and its valid strobe, port A
//   re_b/raddr_b        read request and address, port B
//   rdata_b/rvalid_b    registered read data and its valid strobe, port B
// Modports: master (drives requests), slave (the register file).
// -----------------------------------------------------------------------------
interface reg_file_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);

  logic              clr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;

  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic              rvalid_a;

  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_b;
  logic              rvalid_b;

  modport master (
    output clr, we, waddr, wdata,
    output re_a, raddr_a, re_b, raddr_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b
  );

  modport slave (
    input  clr, we, waddr, wdata,
    input  re_a, raddr_a, re_b, raddr_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b
  );

endinterface

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// DEPTH = 2**ADDR_W registers of WIDTH bits, one write port, two independent
// registered read ports (1-cycle latency), and a single-cycle synchronous clear.
//
// Ports:
//   clk    single clock, all state updates on its rising edge
//   rst_n  asynchronous active-low reset: clears registers and read outputs
//   bus    reg_file_if.slave (clr, we/waddr/wdata, re_x/raddr_x/rdata_x/rvalid_x)
//
// Parameters:
//   WIDTH     data bits per register
//   ADDR_W    address bits; every address is a valid register
//   ZERO_REG  when 1, register 0 reads as zero and ignores writes
//
// Build option:
//   REG_FILE_BYPASS_EN  when defined, a read in the same cycle as a write to the
//                       same address returns the new data, and a read in the
//                       same cycle as clr returns 0. When undefined, reads see
//                       the register contents from before that edge.
// -----------------------------------------------------------------------------
module reg_file #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_file_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  word_t             regs [DEPTH];
  logic [DEPTH-1:0]  wr_sel;
  word_t             rd_next_a;
  word_t             rd_next_b;

  // ---------------------------------------------------------------------------
  // Read value selection. The stored word is looked up at the call site so the
  // function only decides masking and (optionally) forwarding.
  // ---------------------------------------------------------------------------
`ifdef REG_FILE_BYPASS_EN
  function automatic word_t read_value(
    input addr_t addr,
    input word_t stored,
    input logic  clr,
    input logic  we,
    input addr_t waddr,
    input word_t wdata
  );
    word_t v;
    v = stored;
    if (we && (waddr == addr)) v = wdata;
    // Clear wins over the forwarded write, mirroring the storage priority.
    if (clr) v = '0;
    if ((ZERO_REG != 0) && (addr == '0)) v = '0;
    return v;
  endfunction
`else
  function automatic word_t read_value(
    input addr_t addr,
    input word_t stored
  );
    word_t v;
    v = stored;
    if ((ZERO_REG != 0) && (addr == '0)) v = '0;
    return v;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Write decode: one-hot select, suppressed by clr and for the zero register.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any condition so
    // no path leaves it unassigned, which would otherwise infer a latch.
    wr_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_sel[i] = bus.we && !bus.clr && (bus.waddr == addr_t'(i));
    end
    if (ZERO_REG != 0) wr_sel[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Register storage.
  // ---------------------------------------------------------------------------
  // NOTE: this array is built from flops, not a RAM macro, so it can and must
  // be cleared by the asynchronous reset; a RAM-mapped array would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge values of the others regardless of statement order.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) regs[i] <= bus.wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next read data for each port.
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef REG_FILE_BYPASS_EN
    rd_next_a = read_value(bus.raddr_a, regs[bus.raddr_a],
                           bus.clr, bus.we, bus.waddr, bus.wdata);
    rd_next_b = read_value(bus.raddr_b, regs[bus.raddr_b],
                           bus.clr, bus.we, bus.waddr, bus.wdata);
`else
    rd_next_a = read_value(bus.raddr_a, regs[bus.raddr_a]);
    rd_next_b = read_value(bus.raddr_b, regs[bus.raddr_b]);
`endif
  end

  // ---------------------------------------------------------------------------
  // Read output registers. rdata holds when no read is requested; clr alone
  // never touches them. Reset discards any read in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdata_a  <= '0;
      bus.rvalid_a <= 1'b0;
      bus.rdata_b  <= '0;
      bus.rvalid_b <= 1'b0;
    end else begin
      bus.rvalid_a <= bus.re_a;
      bus.rvalid_b <= bus.re_b;
      if (bus.re_a) bus.rdata_a <= rd_next_a;
      if (bus.re_b) bus.rdata_b <= rd_next_b;
    end
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data bits per register.
REQ-002 The block SHALL have parameter ADDR_W, default 3, address bits; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as constant zero and ignores writes.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port clr  input  1  synchronous clear of all registers.
REQ-007 The block SHALL have port we  input  1  write enable.
REQ-008 The block SHALL have port waddr  input  ADDR_W  write address.
REQ-009 The block SHALL have port wdata  input  WIDTH  write data.
REQ-010 The block SHALL have port re_a  input  1  read request, port A.
REQ-011 The block SHALL have port raddr_a  input  ADDR_W  read address, port A.
REQ-012 The block SHALL have port rdata_a  output  WIDTH  registered read data, port A.
REQ-013 The block SHALL have port rvalid_a  output  1  rdata_a updated this cycle, port A.
REQ-014 The block SHALL have ports re_b, raddr_b, rdata_b and rvalid_b, identical to port A.

Function
REQ-015 Write: if we=1 and clr=0 at a rising edge, the block SHALL load wdata into register[waddr].
REQ-016 Write: when ZERO_REG=1, a write to address 0 SHALL have no effect.
REQ-017 Read: if re_x=1 at edge N, rdata_x SHALL show register[raddr_x] after edge N (1-cycle latency), and rvalid_x SHALL be 1 for that cycle.
REQ-018 Hold: if re_x=0, rdata_x SHALL hold its last value and rvalid_x SHALL be 0 after the edge.
REQ-019 Clear: clr=1 at an edge SHALL set all DEPTH registers to 0 in that single cycle.
REQ-020 Clear vs write: clr SHALL take priority over we in the same cycle.
REQ-021 Clear: clr SHALL NOT change rdata_x or rvalid_x other than via a concurrent read.
REQ-022 Same-cycle read and write to the same address, default build: the read SHALL return the pre-write content.
REQ-023 Both ports MAY read the same address in the same cycle; both SHALL return identical data.
REQ-024 Out-of-range addresses cannot occur (DEPTH = 2**ADDR_W); every address SHALL be valid.

Reset
REQ-025 On rst_n=0, immediately and independent of clk, the block SHALL clear all registers, rdata_a and rdata_b to 0 and rvalid_a and rvalid_b to 0.
REQ-026 While rst_n=0, the block SHALL ignore we, clr and re_x.
REQ-027 After reset deassertion, the first edge with rst_n=1 SHALL operate normally.
REQ-028 A read in flight when reset asserts SHALL be discarded, with rvalid_x=0.

Configuration
REQ-029 When macro REG_FILE_BYPASS_EN is defined, a same-cycle read of the address being written SHALL return wdata, or 0 if ZERO_REG=1 and the address is 0.
REQ-030 When REG_FILE_BYPASS_EN is defined, a read in the same cycle as clr=1 SHALL return 0.
REQ-031 When REG_FILE_BYPASS_EN is undefined, behaviour SHALL follow REQ-022, and a read concurrent with clr SHALL return the pre-clear value.

Verification
REQ-032 The bench SHALL cover: reset, then re_a=1 raddr_a=5 -> rdata_a=0x0000, rvalid_a=1 one cycle later.
REQ-033 The bench SHALL cover: we=1 waddr=3 wdata=0xBEEF; next cycle re_a=1 raddr_a=3, re_b=1 raddr_b=3 -> rdata_a=rdata_b=0xBEEF after one edge.
REQ-034 The bench SHALL cover: ZERO_REG=1, write 0x1234 to address 0, then read address 0 -> 0x0000; with ZERO_REG=0 -> 0x1234.
REQ-035 The bench SHALL cover: reg 2=0x00AA; same cycle we=1 waddr=2 wdata=0x0055, re_a=1 raddr_a=2 -> rdata_a=0x00AA (default) or 0x0055 (REG_FILE_BYPASS_EN); next read -> 0x0055.
REQ-036 The bench SHALL cover: fill all 8 registers, assert clr with we=1 waddr=1 wdata=0xFFFF -> all reads return 0x0000.
REQ-037 The bench SHALL cover: assert rst_n=0 mid-cycle after re_a=1 -> rdata_a=0 and rvalid_a=0 immediately, without a clock edge.
